// File: rtl/timekeeper_pkg.sv
// rtl/timekeeper_pkg.sv - shared channel encoding, field widths and time arithmetic for the timekeeper
package timekeeper_pkg;

  localparam int TIME_W_SEC = 6;
  localparam int TIME_W_MIN = 6;
  localparam int TIME_W_HR  = 5;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARMED   = 2'd1,
    ST_RINGING = 2'd2,
    ST_SNOOZED = 2'd3
  } chan_state_t;

  typedef struct packed {
    logic [TIME_W_HR-1:0]  hr;
    logic [TIME_W_MIN-1:0] mn;
  } hm_t;

  // Adds up to two units to a counter already below modulus, wrapping once.
  function automatic logic [5:0] inc_mod(input logic [5:0] v, input logic [1:0] n,
                                         input int unsigned modulus);
    int unsigned s;
    s = 32'(v) + 32'(n);
    if (s >= modulus) s = s - modulus;
    return 6'(s);
  endfunction

  function automatic hm_t add_minutes(input hm_t t, input int unsigned add,
                                      input int unsigned hours);
    int unsigned m;
    int unsigned h;
    hm_t r;
    m = 32'(t.mn) + add;
    h = 32'(t.hr);
    if (m >= 60) begin
      m = m - 60;
      h = h + 1;
    end
    if (h >= hours) h = h - hours;
    r.mn = TIME_W_MIN'(m);
    r.hr = TIME_W_HR'(h);
    return r;
  endfunction

endpackage

// File: rtl/alarm_channel.sv
// rtl/alarm_channel.sv - one alarm channel: alarm time, snooze target, ring timer and state machine
module alarm_channel
  import timekeeper_pkg::*;
#(
  parameter int HOURS      = 12,
  parameter int SNOOZE_MIN = 5,
  parameter int RING_S     = 60
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  min_adj,
  input  logic                  hrs_adj,
  input  logic                  toggle,
  input  logic                  snooze,
  input  logic                  new_sec,
  input  logic [TIME_W_SEC-1:0] cur_sec,
  input  logic [TIME_W_MIN-1:0] cur_min,
  input  logic [TIME_W_HR-1:0]  cur_hr,
  output logic [TIME_W_MIN-1:0] al_min,
  output logic [TIME_W_HR-1:0]  al_hr,
  output logic                  ringing,
  output logic                  enabled
);

  localparam int RW = $clog2(RING_S + 1);

  chan_state_t   state;
  hm_t           target;
  hm_t           now_hm;
  hm_t           snooze_hm;
  logic [RW-1:0] ring_cnt;
  logic          at_minute;
  logic          at_alarm;
  logic          at_target;

  assign now_hm    = '{hr: cur_hr, mn: cur_min};
  assign snooze_hm = add_minutes(now_hm, SNOOZE_MIN, HOURS);
  // Matching only on the :00 second keeps a dismissed alarm silent for the rest of its minute.
  assign at_minute = new_sec && (cur_sec == '0);
  assign at_alarm  = at_minute && (cur_min == al_min) && (cur_hr == al_hr);
  assign at_target = at_minute && (now_hm == target);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state    <= ST_IDLE;
      target   <= '0;
      ring_cnt <= '0;
      al_min   <= '0;
      al_hr    <= '0;
    end else begin
      if (min_adj) al_min <= inc_mod(al_min, 2'd1, 60);
      if (hrs_adj) al_hr <= TIME_W_HR'(inc_mod({1'b0, al_hr}, 2'd1, HOURS));
      case (state)
        ST_IDLE: if (toggle) state <= ST_ARMED;
        ST_ARMED: begin
          if (toggle) state <= ST_IDLE;
          else if (at_alarm) begin
            state    <= ST_RINGING;
            ring_cnt <= '0;
          end
        end
        ST_RINGING: begin
          if (toggle) state <= ST_ARMED;
          else if (snooze) begin
            state  <= ST_SNOOZED;
            target <= snooze_hm;
          end else if (new_sec) begin
            if (ring_cnt == RW'(RING_S - 1)) state <= ST_ARMED;
            else ring_cnt <= ring_cnt + 1'b1;
          end
        end
        ST_SNOOZED: begin
          if (toggle) state <= ST_IDLE;
          else if (at_target) begin
            state    <= ST_RINGING;
            ring_cnt <= '0;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign ringing = (state == ST_RINGING);
  assign enabled = (state != ST_IDLE);

endmodule

// File: rtl/multi_alarm_timekeeper.sv
// rtl/multi_alarm_timekeeper.sv - hh:mm:ss timekeeper with NUM_ALARMS alarm channels and gated buzzer
module multi_alarm_timekeeper
  import timekeeper_pkg::*;
#(
  parameter int CLK_HZ     = 31500000,
  parameter int HOURS      = 12,
  parameter int NUM_ALARMS = 2,
  parameter int BUZZ_HZ    = 3150,
  parameter int SNOOZE_MIN = 5,
  parameter int RING_S     = 60
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    sec_adj,
  input  logic                    min_adj,
  input  logic                    hrs_adj,
  input  logic                    al_sel,
  input  logic                    al_min_adj,
  input  logic                    al_hrs_adj,
  input  logic                    al_toggle,
  input  logic                    snooze,
  output logic [TIME_W_SEC-1:0]   seconds,
  output logic [TIME_W_MIN-1:0]   minutes,
  output logic [TIME_W_HR-1:0]    hours,
  output logic [6*NUM_ALARMS-1:0] al_minutes,
  output logic [5*NUM_ALARMS-1:0] al_hours,
  output logic [1:0]              sel,
  output logic [NUM_ALARMS-1:0]   al_enabled,
  output logic [NUM_ALARMS-1:0]   ringing,
  output logic                    buzzer_out
);

  localparam int PW       = $clog2(CLK_HZ + 1);
  localparam int TONE_PER = CLK_HZ / BUZZ_HZ;
  localparam int TW       = $clog2(TONE_PER + 1);

  logic [PW-1:0] presc;
  logic [PW-1:0] gate_cnt;
  logic [TW-1:0] tone_cnt;
  logic          tick;
  logic          sec_wrap;
  logic          min_wrap;
  logic          new_sec;
  logic          any_ring;

  assign tick     = (presc == PW'(CLK_HZ - 1));
  assign sec_wrap = tick && !sec_adj && (seconds == 6'd59);
  assign min_wrap = sec_wrap && (minutes == 6'd59);

  // Adjust pulses add to the tick carry rather than replacing it.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      presc   <= '0;
      seconds <= '0;
      minutes <= '0;
      hours   <= '0;
      new_sec <= 1'b0;
      sel     <= '0;
    end else begin
      presc   <= (tick || sec_adj) ? '0 : presc + 1'b1;
      new_sec <= tick && !sec_adj;
      if (sec_adj) seconds <= '0;
      else if (tick) seconds <= sec_wrap ? '0 : seconds + 1'b1;
      minutes <= inc_mod(minutes, {1'b0, sec_wrap} + {1'b0, min_adj}, 60);
      hours   <= TIME_W_HR'(inc_mod({1'b0, hours}, {1'b0, min_wrap} + {1'b0, hrs_adj}, HOURS));
      if (al_sel) sel <= (sel == 2'(NUM_ALARMS - 1)) ? '0 : sel + 1'b1;
    end
  end

  for (genvar i = 0; i < NUM_ALARMS; i++) begin : g_ch
    logic hit;
    assign hit = (sel == 2'(i));
    alarm_channel #(
      .HOURS     (HOURS),
      .SNOOZE_MIN(SNOOZE_MIN),
      .RING_S    (RING_S)
    ) u_ch (
      .clk     (clk),
      .reset_n (reset_n),
      .min_adj (al_min_adj && hit),
      .hrs_adj (al_hrs_adj && hit),
      .toggle  (al_toggle && hit),
      .snooze  (snooze),
      .new_sec (new_sec),
      .cur_sec (seconds),
      .cur_min (minutes),
      .cur_hr  (hours),
      .al_min  (al_minutes[6*i +: 6]),
      .al_hr   (al_hours[5*i +: 5]),
      .ringing (ringing[i]),
      .enabled (al_enabled[i])
    );
  end

  assign any_ring = |ringing;

  // Counters sit at zero while silent, so gate and tone restart in phase with the first ring.
  always_ff @(posedge clk) begin
    if (!reset_n || !any_ring) begin
      gate_cnt <= '0;
      tone_cnt <= '0;
    end else begin
      gate_cnt <= (gate_cnt == PW'(CLK_HZ - 1)) ? '0 : gate_cnt + 1'b1;
      tone_cnt <= (tone_cnt == TW'(TONE_PER - 1)) ? '0 : tone_cnt + 1'b1;
    end
  end

  assign buzzer_out = any_ring && (gate_cnt < PW'(CLK_HZ / 2)) && (tone_cnt < TW'(TONE_PER / 2));

endmodule

// File: tb/tb_multi_alarm_timekeeper.sv
// tb/tb_multi_alarm_timekeeper.sv - directed self-checking bench for multi_alarm_timekeeper
module tb_multi_alarm_timekeeper;

  localparam int B_SEC = 0, B_MIN = 1, B_HRS = 2, B_SEL = 3;
  localparam int B_AMIN = 4, B_AHRS = 5, B_TOG = 6, B_SNZ = 7;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [7:0] btn;

  logic [5:0]  seconds, minutes, seconds12, minutes12;
  logic [4:0]  hours, hours12;
  logic [11:0] al_minutes, al_minutes12;
  logic [9:0]  al_hours, al_hours12;
  logic [1:0]  sel, al_enabled, ringing, sel12, al_enabled12, ringing12;
  logic        buzzer_out, buzzer_out12;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  multi_alarm_timekeeper #(
    .CLK_HZ(20), .HOURS(24), .NUM_ALARMS(2), .BUZZ_HZ(5), .SNOOZE_MIN(1), .RING_S(3)
  ) u_dut (
    .clk(clk), .reset_n(reset_n),
    .sec_adj(btn[B_SEC]), .min_adj(btn[B_MIN]), .hrs_adj(btn[B_HRS]), .al_sel(btn[B_SEL]),
    .al_min_adj(btn[B_AMIN]), .al_hrs_adj(btn[B_AHRS]), .al_toggle(btn[B_TOG]), .snooze(btn[B_SNZ]),
    .seconds(seconds), .minutes(minutes), .hours(hours),
    .al_minutes(al_minutes), .al_hours(al_hours), .sel(sel),
    .al_enabled(al_enabled), .ringing(ringing), .buzzer_out(buzzer_out)
  );

  multi_alarm_timekeeper #(
    .CLK_HZ(20), .HOURS(12), .NUM_ALARMS(2), .BUZZ_HZ(5), .SNOOZE_MIN(1), .RING_S(3)
  ) u_dut12 (
    .clk(clk), .reset_n(reset_n),
    .sec_adj(btn[B_SEC]), .min_adj(btn[B_MIN]), .hrs_adj(btn[B_HRS]), .al_sel(btn[B_SEL]),
    .al_min_adj(btn[B_AMIN]), .al_hrs_adj(btn[B_AHRS]), .al_toggle(btn[B_TOG]), .snooze(btn[B_SNZ]),
    .seconds(seconds12), .minutes(minutes12), .hours(hours12),
    .al_minutes(al_minutes12), .al_hours(al_hours12), .sel(sel12),
    .al_enabled(al_enabled12), .ringing(ringing12), .buzzer_out(buzzer_out12)
  );

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse(input int b);
    btn[b] = 1'b1;
    cyc(1);
    btn[b] = 1'b0;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    reset_n = 1'b0;
    btn     = '0;
    cyc(3);
    reset_n = 1'b1;
    check("reset_time", 32'({hours, minutes, seconds}), 32'd0);
    check("reset_chan", 32'({al_enabled, ringing, sel, buzzer_out}), 32'd0);
    check("reset_alarm", 32'({al_hours, al_minutes}), 32'd0);

    // Preset 23:59:xx (11:59:xx on the 12-hour copy), then align seconds.
    repeat (23) pulse(B_HRS);
    repeat (59) pulse(B_MIN);
    check("preset_hm24", 32'({hours, minutes}), 32'({5'd23, 6'd59}));
    check("preset_hr12", 32'(hours12), 32'd11);
    pulse(B_SEC);
    check("sec_adj_clear", 32'(seconds), 32'd0);
    cyc(1180);
    check("t235959", 32'({hours, minutes, seconds}), 32'({5'd23, 6'd59, 6'd59}));
    cyc(20);
    check("rollover24", 32'({hours, minutes, seconds}), 32'd0);
    check("rollover12", 32'({hours12, minutes12, seconds12}), 32'd0);

    // Channel 0 alarm at 00:01.
    pulse(B_AMIN);
    pulse(B_TOG);
    check("ch0_alarm_time", 32'({al_hours[4:0], al_minutes[5:0]}), 32'd1);
    check("ch0_armed", 32'(al_enabled), 32'b01);
    pulse(B_SEC);
    cyc(1199);
    check("t000059", 32'({minutes, seconds, ringing}), 32'({6'd0, 6'd59, 2'b00}));
    cyc(1);
    check("t000100_no_ring_yet", 32'({minutes, seconds, ringing}), 32'({6'd1, 6'd0, 2'b00}));
    cyc(1);
    check("ring_rise", 32'(ringing), 32'b01);
    check("buzz_on", 32'(buzzer_out), 32'd1);
    cyc(2);
    check("buzz_tone_low", 32'(buzzer_out), 32'd0);
    cyc(57);
    check("ring_hold_3s", 32'(ringing), 32'b01);
    cyc(1);
    check("ring_timeout", 32'({al_enabled, ringing}), 32'({2'b01, 2'b00}));

    // Snooze: move alarm to 00:02, snooze at 00:02:01, re-ring at 00:03:00.
    pulse(B_AMIN);
    check("ch0_min_2", 32'(al_minutes[5:0]), 32'd2);
    cyc(1139);
    check("ring_0002", 32'(ringing), 32'b01);
    cyc(19);
    check("t000201", 32'({minutes, seconds}), 32'({6'd2, 6'd1}));
    pulse(B_SNZ);
    check("snoozed", 32'({al_enabled, ringing, buzzer_out}), 32'({2'b01, 2'b00, 1'b0}));
    cyc(1180);
    check("rering_0003", 32'(ringing), 32'b01);
    pulse(B_TOG);
    check("dismiss", 32'({al_enabled, ringing}), 32'({2'b01, 2'b00}));
    cyc(1180);
    check("no_rering", 32'({minutes, seconds, ringing}), 32'({6'd3, 6'd59, 2'b00}));

    // Both channels at 00:05; one snooze covers both.
    repeat (3) pulse(B_AMIN);
    pulse(B_SEL);
    repeat (5) pulse(B_AMIN);
    pulse(B_TOG);
    check("sel1", 32'(sel), 32'd1);
    check("both_alarm_min", 32'(al_minutes), 32'({6'd5, 6'd5}));
    check("both_armed", 32'(al_enabled), 32'b11);
    cyc(1209);
    check("both_ring", 32'({ringing, buzzer_out}), 32'({2'b11, 1'b1}));
    pulse(B_SNZ);
    check("both_snoozed", 32'({al_enabled, ringing}), 32'({2'b11, 2'b00}));

    // min_adj on a minute-carrying tick, then sec_adj on a tick.
    cyc(1197);
    check("t000559", 32'({minutes, seconds}), 32'({6'd5, 6'd59}));
    pulse(B_MIN);
    check("min_carry_plus_adj", 32'({hours, minutes, seconds}), 32'({5'd0, 6'd7, 6'd0}));
    cyc(19);
    pulse(B_SEC);
    check("sec_adj_over_tick", 32'({minutes, seconds}), 32'({6'd7, 6'd0}));
    cyc(19);
    check("tick_delayed", 32'(seconds), 32'd0);
    cyc(1);
    check("tick_after_20", 32'({seconds, ringing}), 32'({6'd1, 2'b00}));

    // Re-arm channel 1 at 00:08 and reset while it rings.
    pulse(B_TOG);
    check("ch1_snooze_to_idle", 32'(al_enabled), 32'b01);
    repeat (3) pulse(B_AMIN);
    pulse(B_TOG);
    check("ch1_rearmed", 32'({al_enabled, al_minutes[11:6]}), 32'({2'b11, 6'd8}));
    cyc(1176);
    check("ch1_ring_0008", 32'({ringing, buzzer_out}), 32'({2'b10, 1'b1}));
    reset_n = 1'b0;
    cyc(1);
    check("reset_ring", 32'({al_enabled, ringing, buzzer_out}), 32'd0);
    check("reset_time_sel", 32'({hours, minutes, seconds, sel}), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/multi_alarm_timekeeper.md
# multi_alarm_timekeeper

- Parametrised timekeeping core: keeps hh:mm:ss, runs NUM_ALARMS independent alarm channels with snooze and auto-timeout, and drives a gated buzzer tone.
- Sits between the button_debounce instances (its pulse inputs) and the clock-face renderer (its time/alarm outputs).
- Supersedes the single-alarm, fixed-12-hour timekeeping logic of the current VGA clock top level.

## Interface
Parameters:
- CLK_HZ, 31500000, input clock frequency; prescaler divides to a 1 Hz tick
- HOURS, 12, hour modulus, 12 or 24; hours count 0..HOURS-1
- NUM_ALARMS, 2, alarm channels, 1..4
- BUZZ_HZ, 3150, buzzer tone frequency
- SNOOZE_MIN, 5, snooze length in minutes, 1..59
- RING_S, 60, seconds a channel rings before auto-return to ARMED

Ports:
- clk  in  1  system clock
- reset_n  in  1  reset; synchronous, active-low
- sec_adj  in  1  one-cycle pulse: clear seconds and prescaler
- min_adj  in  1  pulse: minutes +1 mod 60, no carry into hours
- hrs_adj  in  1  pulse: hours +1 mod HOURS
- al_sel  in  1  pulse: selected channel +1 mod NUM_ALARMS
- al_min_adj  in  1  pulse: selected alarm minutes +1 mod 60
- al_hrs_adj  in  1  pulse: selected alarm hours +1 mod HOURS
- al_toggle  in  1  pulse: toggle/dismiss selected channel
- snooze  in  1  pulse: snooze every RINGING channel
- seconds, minutes  out  6 each  current time
- hours  out  5  current hour
- al_minutes  out  6*NUM_ALARMS  packed, channel 0 in LSBs
- al_hours  out  5*NUM_ALARMS  packed, channel 0 in LSBs
- sel  out  2  selected channel index
- al_enabled  out  NUM_ALARMS  channel not IDLE
- ringing  out  NUM_ALARMS  channel RINGING
- buzzer_out  out  1  gated tone

## Operation
- Reset (reset_n low at a clk edge): all outputs, counters, prescalers and channel states are 0/IDLE.
- Tick: the prescaler counts 0..CLK_HZ-1 and pulses `tick` on the terminal count. The ripple chain seconds→minutes→hours resolves in the same cycle; at 23:59:59 (HOURS=24) the next value is 00:00:00.
- Simultaneous events:
  - Adjust pulses combine additively with the tick carry. Example: minute carry plus min_adj in the same cycle advances minutes by 2 mod 60.
  - sec_adj overrides the tick: seconds = 0, prescaler = 0.
- Channel FSM, one per channel: IDLE, ARMED, RINGING, SNOOZED.
  - IDLE → ARMED: al_toggle on the selected channel.
  - ARMED → IDLE: al_toggle on the selected channel.
  - ARMED → RINGING: new_sec with hh:mm:00 equal to the alarm time.
  - RINGING → ARMED: al_toggle on the selected channel, or RING_S seconds elapsed.
  - RINGING → SNOOZED: snooze. Capture target = current time + SNOOZE_MIN (minute wrap carries to hours mod HOURS).
  - SNOOZED → RINGING: new_sec with hh:mm:00 equal to the target.
  - SNOOZED → IDLE: al_toggle on the selected channel.
- Alarm adjust: editing a channel's time while it is RINGING or SNOOZED leaves its state unchanged.
- Input priority within a cycle: reset > al_toggle > snooze > match/timeout.
- Buzzer: buzzer_out = (any ringing) AND (1 Hz gate high during the first half of each second) AND (BUZZ_HZ square wave). Output 0 whenever no channel rings.

## Timing
- Cycle T: tick (or adjust pulse) asserts.
- T+1: time registers update; new_sec registered and high for one cycle.
- T+2: channel FSM state, ringing and al_enabled update.
- al_sel, al_*_adj and al_toggle effects are visible one cycle after the pulse.
- Buzzer gate and tone phase reset to 0 when the first channel enters RINGING.
- A channel dismissed at hh:mm:00 does not re-ring in that minute, because matching happens only on new_sec with seconds == 0.
- Reset asserted mid-ring: ringing and buzzer_out are 0 on the following cycle.

## Structure
- Package timekeeper_pkg holds:
  - channel state encoding (IDLE=0, ARMED=1, RINGING=2, SNOOZED=3)
  - TIME_W_SEC/MIN=6, TIME_W_HR=5
  - an add-minutes-with-hour-wrap function
- Sub-module alarm_channel, instantiated NUM_ALARMS times in a generate loop. It holds that channel's alarm time, snooze target, ring-second counter and FSM.
- The top level holds the prescalers, the time counters, the sel counter and the buzzer gating.

## Test plan
All scenarios use CLK_HZ=20, BUZZ_HZ=5, RING_S=3, SNOOZE_MIN=1.
- Rollover, HOURS=24: preset 23:59:59 via adjusts, wait 20 cycles → 00:00:00. With HOURS=12 from 11:59:59 → 00:00:00.
- Arm channel 0 at 00:01, run from 00:00:58:
  - ringing[0] rises 2 cycles after the tick that shows 00:01:00;
  - falls after 3 seconds;
  - channel stays ARMED.
- Ringing channel 0 + snooze at 00:01:01 → SNOOZED, buzzer_out 0; re-rings at 00:02:00; al_toggle → ARMED, no ring later in 00:02.
- al_sel then arm channel 1 at 00:01 alongside channel 0 at 00:01 → both ringing bits set; one snooze pulse moves both to SNOOZED.
- min_adj coincident with a minute-carrying tick at 00:05:59 → 00:07:00. sec_adj coincident with a tick → seconds 0, next tick 20 cycles later.
- reset_n low while ringing → all outputs 0 next cycle, al_enabled 0.
